// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

   localparam int DMEM_WORD_BYTES = 4;
   localparam int DMEM_LAT_W      = 4;

   // Any address bit above the word index makes the access fall outside the array.
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
      return (addr >> (aw + $clog2(DMEM_WORD_BYTES))) == 32'd0;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM, synchronous write and read, no reset so an SRAM macro can replace it.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic                           re,
   input  logic [AW-1:0]                  addr,
   input  logic [DMEM_WORD_BYTES*8-1:0]   wdata,
   output logic [DMEM_WORD_BYTES*8-1:0]   rdata
);

   logic [DMEM_WORD_BYTES*8-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
      if (re)
         rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: IDLE/WAIT/RESP FSM in front of dmem_array.
// Optional misalignment fault reporting is enabled with `define DMEM_ALIGN_CHECK_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data_address,
   input  logic [31:0] write_data,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [31:0] read_data,
   output logic        mem_ready,
   output logic        mem_error
);

   localparam int AW = $clog2(DEPTH);

   dmem_state_t           state;
   dmem_state_t           state_next;
   logic [DMEM_LAT_W-1:0] count;
   logic [AW-1:0]         index_q;
   logic [31:0]           wdata_q;
   logic                  write_q;
   logic                  in_range_q;
   logic                  misaligned_q;

   logic                  accept;
   logic                  finish;
   logic                  array_we;
   logic                  array_re;
   logic                  read_load;
   logic                  req_misaligned;
   logic [AW-1:0]         array_addr;
   logic [31:0]           array_rdata;

`ifdef DMEM_ALIGN_CHECK_EN
   assign req_misaligned = (data_address[1:0] != 2'b00);
`else
   logic byte_offset_unused;
   assign byte_offset_unused = ^data_address[1:0];
   assign req_misaligned     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (mem_read || mem_write) state_next = WAIT;
         WAIT:    if (count == '0) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The access itself happens on the WAIT->RESP edge; RESP only presents the completion.
   always_comb begin
      accept    = 1'b0;
      finish    = 1'b0;
      array_we  = 1'b0;
      read_load = 1'b0;
      mem_ready = 1'b0;
      mem_error = 1'b0;
      case (state)
         IDLE: accept = mem_read | mem_write;
         WAIT: begin
            finish    = (count == '0);
            array_we  = finish & write_q & in_range_q & ~misaligned_q;
            read_load = finish & ~write_q & ~misaligned_q;
         end
         RESP: begin
            mem_ready = 1'b1;
            mem_error = misaligned_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count        <= '0;
         index_q      <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         in_range_q   <= 1'b0;
         misaligned_q <= 1'b0;
      end else if (accept) begin
         count        <= DMEM_LAT_W'(LATENCY - 1);
         index_q      <= data_address[AW+1:2];
         wdata_q      <= write_data;
         write_q      <= mem_write;
         in_range_q   <= addr_in_range(data_address, AW);
         misaligned_q <= req_misaligned;
      end else if (state == WAIT && count != '0) begin
         count <= count - DMEM_LAT_W'(1);
      end
   end

   // The RAM reads the live address while idle so the word is ready even for LATENCY=1.
   assign array_addr = (state == IDLE) ? data_address[AW+1:2] : index_q;
   assign array_re   = (state != RESP);

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (array_we),
      .re    (array_re),
      .addr  (array_addr),
      .wdata (wdata_q),
      .rdata (array_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         read_data <= '0;
      else if (read_load)
         read_data <= in_range_q ? array_rdata : 32'h0;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a word-level memory model predicts every completion.
module tb_dmem_responder;

   localparam int DEPTH   = 64;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] data_address = '0;
   logic [31:0] write_data = '0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] read_data;
   logic        mem_ready;
   logic        mem_error;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          ready_cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] model_mem [DEPTH];
   logic [31:0] model_rd = '0;
   logic        prev_ready = 1'b0;
   int          cyc = 0;
   int          last_ready_cyc = -10;
   int          n_checks = 0;
   int          n_fails = 0;

   dmem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_address (data_address),
      .write_data   (write_data),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .read_data    (read_data),
      .mem_ready    (mem_ready),
      .mem_error    (mem_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference behaviour: a plain word array, last-read register and fault flag.
   task automatic model_access(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input int accept_cyc, output exp_t e);
      logic mis;
      logic in_rng;
      int   idx;
`ifdef DMEM_ALIGN_CHECK_EN
      mis = (addr % 4) != 0;
`else
      mis = 1'b0;
`endif
      in_rng = addr < 32'(DEPTH * 4);
      idx    = int'((addr / 4) % DEPTH);
      if (!mis) begin
         if (wr) begin
            if (in_rng) model_mem[idx] = data;
         end else if (rd) begin
            model_rd = in_rng ? model_mem[idx] : 32'h0;
         end
      end
      e.rd        = model_rd;
      e.err       = mis;
      e.ready_cyc = accept_cyc + LATENCY;
   endtask

   // Called just after a falling edge; behaves like the core: holds the request until mem_ready.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input int gap);
      int   accept_cyc;
      exp_t e;
      logic seen;
      if (gap > 0) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
         repeat (gap) @(negedge clk);
      end
      accept_cyc = (cyc + 1 > last_ready_cyc + 2) ? cyc + 1 : last_ready_cyc + 2;
      model_access(rd, wr, addr, data, accept_cyc, e);
      sb.push_back(e);
      data_address = addr;
      write_data   = data;
      mem_read     = rd;
      mem_write    = wr;
      seen = 1'b0;
      for (int i = 0; i < LATENCY + 6 && !seen; i++) begin
         @(negedge clk);
         seen = mem_ready;
      end
      if (!seen) begin
         n_checks++;
         n_fails++;
         $display("[TB] FAIL ready_timeout: got no mem_ready, expected one at cycle %0d", e.ready_cyc);
         sb.delete();
      end
      last_ready_cyc = cyc;
   endtask

   always @(negedge clk) begin
      if (rst_n && mem_ready) begin
         if (prev_ready) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL ready_pulse: got mem_ready high two cycles, expected one");
         end
         if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL unexpected_ready: got mem_ready at cycle %0d, expected none", cyc);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("ready_cycle", 32'(cyc), 32'(mon_e.ready_cyc));
            checkOutput("read_data", read_data, mon_e.rd);
            checkOutput("mem_error", {31'b0, mem_error}, {31'b0, mon_e.err});
         end
      end
      prev_ready = mem_ready;
   end

   task automatic reset_mid_write();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      data_address = 32'h8;
      write_data   = 32'h55;
      mem_write    = 1'b1;
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      mem_write = 1'b0;
      #1;
      checkOutput("rst_mid_ready", {31'b0, mem_ready}, 32'h0);
      checkOutput("rst_mid_error", {31'b0, mem_error}, 32'h0);
      checkOutput("rst_mid_rdata", read_data, 32'h0);
      repeat (3) @(negedge clk);
      checkOutput("rst_hold_ready", {31'b0, mem_ready}, 32'h0);
      rst_n          = 1'b1;
      model_rd       = '0;
      last_ready_cyc = -10;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      int unsigned kind;
      int unsigned where;

      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_ready", {31'b0, mem_ready}, 32'h0);
      checkOutput("reset_error", {31'b0, mem_error}, 32'h0);
      checkOutput("reset_rdata", read_data, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] filling memory");
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'b0, 1'b1, 32'(i * 4), $urandom, 0);

      $display("[TB] directed sequences");
      applyStimulus(1'b0, 1'b1, 32'h4, 32'd100, 1);
      applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 1);
      applyStimulus(1'b1, 1'b1, 32'h10, 32'd7, 1);
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1);
      applyStimulus(1'b0, 1'b1, 32'h0, 32'd8, 1);
      applyStimulus(1'b0, 1'b1, 32'h100, 32'h55, 1);
      applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1);
      applyStimulus(1'b0, 1'b1, 32'h8, 32'd1, 1);
      reset_mid_write();
      applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 1);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1);
      applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 0);
      applyStimulus(1'b1, 1'b0, 32'h6, 32'h0, 1);
      applyStimulus(1'b0, 1'b1, 32'h6, 32'hdead_beef, 0);
      applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 0);

      $display("[TB] random traffic");
      for (int n = 0; n < 200; n++) begin
         kind  = $urandom_range(0, 9);
         where = $urandom_range(0, 9);
         if (where <= 5)
            a = 32'($urandom_range(0, DEPTH * 4 - 1)) & ~32'h3;
         else if (where <= 7)
            a = 32'($urandom_range(0, DEPTH * 4 - 1));
         else
            a = 32'($urandom_range(DEPTH * 4, 32'hFFFF_FFFF));
         d = $urandom;
         applyStimulus(kind <= 3 || kind == 7, kind >= 4, a, d, int'($urandom_range(0, 2)));
      end

      mem_read  = 1'b0;
      mem_write = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
